rr_arbiter: RTL and testbench
=============================

# rr_arbiter

Round-robin arbiter that shares a single display/encode resource between eight requesters driven from the board switches. It sits in front of the 3-bit index encoder and 7-segment decoder path. It grants one requester at a time for a bounded hold quantum and drives the granted index to the 7-segment digit. A global enable gates all requests, and an indicator shows when a grant is active.

## Interface
Parameters:
- HOLD_CYCLES, 4, maximum consecutive cycles one requester keeps the grant while others wait; legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  global request enable; when low, every request bit is treated as 0.
- req  input  8  request vector, bit i = requester i.
- done  input  1  single-cycle release pulse from the current grant holder; ignored when no grant is active.
- grant  output  8  registered one-hot grant, or all zeros.
- gidx  output  3  registered binary index of the granted requester; holds its last value when idle.
- busy  output  1  high exactly when grant != 0.
- seg  output  7  active-low 7-segment pattern of gidx, ordered {g,f,e,d,c,b,a}; blank (7'b1111111) when busy = 0.

## Operation
- Effective request: ereq = req & {8{enable}}.
- State machine:
  - IDLE (grant = 0). The block moves to GRANT when ereq != 0.
  - GRANT (one-hot grant). The block stays in GRANT or re-arbitrates on release. It returns to IDLE when a release occurs and ereq == 0, or when enable drops.
- Selection order:
  - Search ereq starting at index ptr+1 and wrap 7 to 0. The first set bit wins.
  - ptr is the index of the last granted requester. Reset value of ptr is 7, so the first search starts at 0.
  - On every new grant, ptr is set to the winner's index.
- Release conditions while in GRANT. Any one of these is sufficient, and coincident conditions cause a single release:
  - done = 1.
  - ereq[gidx] = 0, meaning the holder dropped its request or enable went low.
  - hold counter = HOLD_CYCLES-1 and some other ereq bit is set.
- Hold counter (8-bit):
  - Cleared to 0 on every new grant, including a re-grant to the same index.
  - Increments each GRANT cycle otherwise.
  - When the counter reaches HOLD_CYCLES-1 and no other requester is waiting, it holds at that value and the holder keeps the grant.
- Re-arbitration on release:
  - The next winner is chosen in the same cycle, with zero bubble.
  - The search starts at the releasing index + 1, so the releasing requester is re-granted only if it is the sole remaining requester.
- seg decode of gidx: 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000.
- Reset values: grant = 0, gidx = 0, busy = 0, seg = 1111111, ptr = 7, counter = 0, state IDLE.
- Reset asserted mid-grant forces all reset values immediately (asynchronously). The first grant after reset release follows the reset value of ptr.

## Timing
- Latency: ereq sampled at edge N drives grant, gidx and busy valid after edge N. One cycle from request to grant.
- Release seen at edge N: the new grant, or zero, appears after edge N. The old grant never overlaps the new one.
- A single requester with a continuous request keeps the grant indefinitely.
- Fairness: with all 8 requesting and no done, each requester holds the grant for exactly HOLD_CYCLES cycles in order 0..7, 0, ...
- busy and seg are combinational from registered state, with no added latency.
- A done pulse while in IDLE has no effect.

## Configuration
- RR_ARBITER_STRICT_PRIO_EN:
  - Defined: selection is fixed priority. The highest set ereq index wins, and ptr is unused.
  - Defined: timeout release happens only if a higher-index requester is waiting. Otherwise the holder keeps the grant.
  - Undefined (default): round-robin behaviour as described above.

## Test plan
- Reset: rst = 1 with req = 8'hFF → grant = 0, busy = 0, seg = 1111111. After release with enable = 1, the first grant is 8'h01, gidx = 0, seg = 1000000.
- Rotation: HOLD_CYCLES = 4, req = 8'hFF held → grant = 01, 02, 04, … 80, 01, each lasting exactly 4 cycles.
- Early release: req = 8'h22 with the grant at index 1 and done pulsed on its 2nd cycle → grant becomes 8'h20 on the next edge, with no idle cycle.
- Sole holder: req = 8'h08 for 20 cycles → grant stays 8'h08 and gidx = 3 throughout, seg = 0110000.
- Enable drop: enable falls during a grant → grant = 0 after the next edge. When enable rises again with req = 8'h81 and ptr = 0, the grant is 8'h80.
- Strict mode (macro defined): req = 8'h81 held → grant stays 8'h80. When req becomes 8'h01, the grant moves to 8'h01 one edge later.

Source files
------------

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant of a shared 7-seg display among 8 requesters (RR_ARBITER_STRICT_PRIO_EN selects fixed priority)
module rr_arbiter #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] gidx,
  output logic       busy,
  output logic [6:0] seg
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [7:0] LAST = 8'(HOLD_CYCLES - 1);
  state_t state, state_n;
  logic [7:0] ereq, others, grant_n, cnt, cnt_n;
  logic [2:0] gidx_n, win;
  logic waiting, rel, take;
  assign ereq = req & {8{enable}};
  assign others = ereq & ~grant;
`ifdef RR_ARBITER_STRICT_PRIO_EN
  assign waiting = |(others >> gidx);
  // highest requesting index wins
  always_comb begin
    win = 3'd0;
    for (int k = 0; k < 8; k++) if (ereq[k]) win = 3'(k);
  end
`else
  logic [2:0] ptr;
  assign waiting = |others;
  // first requester after ptr wins, wrapping 7 to 0; ptr itself is checked last
  always_comb begin
    win = ptr;
    for (int k = 8; k >= 1; k--) if (ereq[ptr + 3'(k)]) win = ptr + 3'(k);
  end
  // last granted index, the starting point of the next search
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= 3'd7;
    else if (take) ptr <= win;
`endif
  // release detection, same-cycle re-arbitration and hold counting
  always_comb begin
    rel = state == GRANT && (done || !ereq[gidx] || (cnt == LAST && waiting));
    take = |ereq && (state == IDLE || rel);
    state_n = take ? GRANT : rel ? IDLE : state;
    grant_n = take ? 8'd1 << win : rel ? 8'd0 : grant;
    gidx_n = take ? win : gidx;
    cnt_n = take ? 8'd0 : (state == GRANT && cnt != LAST) ? cnt + 8'd1 : cnt;
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      grant <= 8'd0;
      gidx <= 3'd0;
      cnt <= 8'd0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      gidx <= gidx_n;
      cnt <= cnt_n;
    end
  assign busy = |grant;
  // active-low {g,f,e,d,c,b,a} digit of the granted index, blank when idle
  always_comb begin
    case (gidx)
      3'd0: seg = 7'b1000000;
      3'd1: seg = 7'b1111001;
      3'd2: seg = 7'b0100100;
      3'd3: seg = 7'b0110000;
      3'd4: seg = 7'b0011001;
      3'd5: seg = 7'b0010010;
      3'd6: seg = 7'b0000010;
      default: seg = 7'b1111000;
    endcase
    if (!busy) seg = 7'b1111111;
  end
endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: table, directed and randomized model checks of rr_arbiter
module tb_rr_arbiter;
  localparam int HOLD = 4;
  logic clk = 1'b0;
  logic rst, enable, done, busy;
  logic [7:0] req, grant;
  logic [2:0] gidx;
  logic [6:0] seg;
  int checks = 0;
  int errors = 0;
  logic [6:0] seg_tab [8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};
  int m_holder, m_last, m_held;
  logic [2:0] m_gidx;
  typedef struct {logic en; logic [7:0] r; logic d; logic [7:0] g; logic [2:0] i;} vec_t;
  vec_t tab [16];

  rr_arbiter #(.HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .enable(enable), .req(req), .done(done),
    .grant(grant), .gidx(gidx), .busy(busy), .seg(seg));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] eg, input logic [2:0] ei);
    chk({tag, " grant"}, grant, eg);
    chk({tag, " gidx"}, {5'd0, gidx}, {5'd0, ei});
    chk({tag, " busy"}, {7'd0, busy}, {7'd0, eg != 8'd0});
    chk({tag, " seg"}, {1'b0, seg}, {1'b0, eg != 8'd0 ? seg_tab[ei] : 7'h7f});
  endtask

  function automatic int pick(input logic [7:0] e, input int base);
`ifdef RR_ARBITER_STRICT_PRIO_EN
    for (int k = 7; k >= 0; k--) if (e[k]) return k;
`else
    for (int k = 1; k <= 8; k++) if (e[(base + k) % 8]) return (base + k) % 8;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_holder = -1;
    m_last = 7;
    m_held = 0;
    m_gidx = 3'd0;
  endtask

  task automatic model_step(input logic e, input logic [7:0] r, input logic d);
    logic [7:0] ee;
    logic wait_any, rel;
    ee = e ? r : 8'd0;
    if (m_holder < 0) begin
      if (ee != 0) begin
        m_holder = pick(ee, m_last);
        m_held = 1;
      end
    end else begin
      wait_any = 1'b0;
      for (int k = 0; k < 8; k++)
`ifdef RR_ARBITER_STRICT_PRIO_EN
        if (k > m_holder && ee[k]) wait_any = 1'b1;
`else
        if (k != m_holder && ee[k]) wait_any = 1'b1;
`endif
      rel = d || !ee[m_holder] || (m_held >= HOLD && wait_any);
      if (rel) begin
        m_holder = ee == 0 ? -1 : pick(ee, m_holder);
        m_held = 1;
      end else m_held++;
    end
    if (m_holder >= 0) begin
      m_last = m_holder;
      m_gidx = 3'(m_holder);
    end
  endtask

  function automatic logic [7:0] m_grant();
    return m_holder < 0 ? 8'd0 : 8'd1 << m_holder;
  endfunction

  task automatic cycle(input logic e, input logic [7:0] r, input logic d);
    enable = e;
    req = r;
    done = d;
    @(posedge clk);
    model_step(e, r, d);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b1;
    req = 8'hFF;
    done = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_out("reset", 8'd0, 3'd0);
    rst = 1'b0;
  endtask

  initial begin
    tab[0]  = '{1, 8'hFF, 0, 8'h01, 3'd0};
    tab[1]  = '{1, 8'hFF, 0, 8'h01, 3'd0};
    tab[2]  = '{1, 8'hFF, 0, 8'h01, 3'd0};
    tab[3]  = '{1, 8'hFF, 0, 8'h01, 3'd0};
    tab[4]  = '{1, 8'hFF, 0, 8'h02, 3'd1};
    tab[5]  = '{1, 8'h22, 1, 8'h20, 3'd5};
    tab[6]  = '{1, 8'h08, 0, 8'h08, 3'd3};
    tab[7]  = '{1, 8'h08, 0, 8'h08, 3'd3};
    tab[8]  = '{1, 8'h08, 0, 8'h08, 3'd3};
    tab[9]  = '{1, 8'h08, 0, 8'h08, 3'd3};
    tab[10] = '{0, 8'h08, 0, 8'h00, 3'd3};
    tab[11] = '{1, 8'h81, 0, 8'h80, 3'd7};
    tab[12] = '{1, 8'h81, 1, 8'h01, 3'd0};
    tab[13] = '{1, 8'h00, 1, 8'h00, 3'd0};
    tab[14] = '{1, 8'h00, 1, 8'h00, 3'd0};
    tab[15] = '{1, 8'h10, 1, 8'h10, 3'd4};
    do_reset();
`ifndef RR_ARBITER_STRICT_PRIO_EN
    for (int v = 0; v < 16; v++) begin
      cycle(tab[v].en, tab[v].r, tab[v].d);
      check_out($sformatf("vec%0d", v), tab[v].g, tab[v].i);
    end
    do_reset();
    for (int t = 0; t < 8 * HOLD * 2 + 3; t++) begin
      cycle(1, 8'hFF, 0);
      check_out($sformatf("rotate%0d", t), 8'd1 << ((t / HOLD) % 8), 3'((t / HOLD) % 8));
    end
    do_reset();
    cycle(1, 8'h01, 0);
    check_out("en_first", 8'h01, 3'd0);
    cycle(0, 8'h01, 0);
    check_out("en_drop", 8'h00, 3'd0);
    cycle(1, 8'h81, 0);
    check_out("en_rise", 8'h80, 3'd7);
`else
    for (int t = 0; t < 10; t++) begin
      cycle(1, 8'h81, 0);
      check_out("strict_hi", 8'h80, 3'd7);
    end
    cycle(1, 8'h01, 0);
    check_out("strict_lo", 8'h01, 3'd0);
`endif
    for (int t = 0; t < 20; t++) begin
      cycle(1, 8'h08, 0);
      check_out("sole", 8'h08, 3'd3);
    end
    cycle(1, 8'hFF, 0);
    #2;
    rst = 1'b1;
    #1;
    check_out("async_reset", 8'd0, 3'd0);
    model_reset();
    rst = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      logic [7:0] r;
      case ($urandom_range(0, 3))
        0: r = 8'hFF;
        1: r = 8'd1 << $urandom_range(0, 7);
        default: r = 8'($urandom);
      endcase
      cycle($urandom_range(0, 15) != 0, r, $urandom_range(0, 5) == 0);
      check_out("rand", m_grant(), m_gidx);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
